// File: rtl/rv32i_dmem_responder_pkg.sv
// Shared constants, types and helpers for the RV32I data-memory responder.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package rv32i_dmem_responder_pkg;

    localparam logic [31:0] DMEM_BASE_ADDR = 32'h0000_1000;
    localparam int          DMEM_DEPTH     = 1024;
    localparam int          WAIT_W         = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // One load/store request as seen on the bus.
    typedef struct packed {
        logic [31:0] addr;
        logic        wr_en;
        logic [3:0]  wr_mask;
        logic [31:0] dat;
    } req_t;

    // Unsigned window test, done in 33 bits so the upper bound cannot wrap.
    function automatic logic in_window(input logic [31:0] addr,
                                       input logic [31:0] base,
                                       input int          depth);
        logic [32:0] a;
        logic [32:0] lo;
        logic [32:0] hi;
        a  = {1'b0, addr};
        lo = {1'b0, base};
        hi = lo + (33'(depth) << 2);
        return (a >= lo) && (a < hi);
    endfunction

endpackage

// File: rtl/rv32i_dmem_responder_if.sv
// Load/store bus between the memory-access stage (master) and the data memory (slave).
// Latency: n/a (wires only).
// Backpressure: stall from the slave means the presented request was not taken.
interface rv32i_dmem_responder_if;
    logic        stb;
    logic [31:0] addr;
    logic        wr_en;
    logic [3:0]  wr_mask;
    logic [31:0] data_store;
    logic [31:0] data_load;
    logic        ack;
    logic        err;
    logic        stall;

    modport master (
        output stb, addr, wr_en, wr_mask, data_store,
        input  data_load, ack, err, stall
    );

    modport slave (
        input  stb, addr, wr_en, wr_mask, data_store,
        output data_load, ack, err, stall
    );
endinterface

// File: rtl/rv32i_dmem_ram.sv
// Single-port DEPTH x 32 RAM with per-byte write enables and a registered read port.
// Latency: read data appears one clock after en; writes land on the same edge.
// Backpressure: none; accepts an access every cycle en is high.
module rv32i_dmem_ram #(
    parameter int    DEPTH     = 1024,
    parameter string INIT_FILE = "",
    localparam int   AW        = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          en,
    input  logic [AW-1:0] idx,
    input  logic [3:0]    we,
    input  logic [31:0]   wdat,
    output logic [31:0]   rdat
);

    logic [31:0] mem [DEPTH];

    // Byte-masked write; the array itself is never reset.
    always_ff @(posedge i_clk) begin
        if (en) begin
            for (int b = 0; b < 4; b++) begin
                if (we[b]) begin
                    mem[idx][8*b +: 8] <= wdat[8*b +: 8];
                end
            end
        end
    end

    // Registered read; sees the pre-write word and holds between accesses.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rdat <= '0;
        end else if (en) begin
            rdat <= mem[idx];
        end
    end

endmodule

// File: rtl/rv32i_dmem_responder.sv
// Data-memory responder: byte-masked stores / word loads on a local RAM with window check.
// Latency: ack in cycle C0+1+WAIT_STATES after acceptance in C0; one request/cycle when WAIT_STATES=0.
// Backpressure: stall is high while counting wait states; requests are accepted in IDLE and RESP only.
module rv32i_dmem_responder
    import rv32i_dmem_responder_pkg::*;
#(
    parameter int          MEM_DEPTH     = DMEM_DEPTH,
    parameter logic [31:0] BASE_ADDR     = DMEM_BASE_ADDR,
    parameter int          WAIT_STATES   = 0,
    parameter string       MEM_INIT_FILE = ""
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    rv32i_dmem_responder_if.slave bus
);

    localparam int AW = $clog2(MEM_DEPTH);
    localparam logic [WAIT_W-1:0] WAIT_LOAD =
        WAIT_W'((WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0);

    state_t            state;
    state_t            state_nxt;
    logic [WAIT_W-1:0] cnt;
    req_t              req_live;
    req_t              req_q;
    req_t              req_acc;
    logic              accept;
    logic              access;
    logic              acc_in_win;
    logic [31:0]       acc_off;
    logic [AW-1:0]     acc_idx;
    logic [3:0]        ram_we;
    logic              ram_en;
    logic [31:0]       ram_rdat;
    logic              err_q;
    logic              unused_off;

    assign req_live = '{addr:    bus.addr,
                        wr_en:   bus.wr_en,
                        wr_mask: bus.wr_mask,
                        dat:     bus.data_store};

    // A new request is only taken when not counting wait states.
    assign accept = bus.stb && (state != ST_WAIT);

    // Pick which request hits the RAM and when: live inputs with no wait states,
    // otherwise the captured copy on the last wait cycle.
    always_comb begin
        access  = 1'b0;
        req_acc = req_live;
        if (WAIT_STATES == 0) begin
            access  = accept;
            req_acc = req_live;
        end else begin
            access  = (state == ST_WAIT) && (cnt == '0);
            req_acc = req_q;
        end
    end

    // Window decode and word index relative to the base address.
    assign acc_in_win = in_window(req_acc.addr, BASE_ADDR, MEM_DEPTH);
    assign acc_off    = req_acc.addr - BASE_ADDR;
    assign acc_idx    = acc_off[AW+1:2];
    assign unused_off = ^{acc_off[31:AW+2], acc_off[1:0]};
    assign ram_en     = access && acc_in_win;
    assign ram_we     = req_acc.wr_en ? req_acc.wr_mask : 4'b0000;

    rv32i_dmem_ram #(
        .DEPTH     (MEM_DEPTH),
        .INIT_FILE (MEM_INIT_FILE)
    ) u_ram (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .en      (ram_en),
        .idx     (acc_idx),
        .we      (ram_we),
        .wdat    (req_acc.dat),
        .rdat    (ram_rdat)
    );

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; RESP with a pending strobe chains straight into the next request.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (bus.stb) begin
                    state_nxt = (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt == '0) begin
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                if (bus.stb) begin
                    state_nxt = (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Bus outputs decoded from state; err and load data only meaningful with ack.
    always_comb begin
        bus.stall     = (state == ST_WAIT);
        bus.ack       = (state == ST_RESP);
        bus.err       = (state == ST_RESP) && err_q;
        bus.data_load = err_q ? 32'h0 : ram_rdat;
    end

    // Wait counter: loaded on acceptance, counts down to zero while waiting.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt <= '0;
        end else if (accept && (WAIT_STATES > 0)) begin
            cnt <= WAIT_LOAD;
        end else if ((state == ST_WAIT) && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    // Request capture so the initiator's inputs need not stay stable after acceptance.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            req_q <= '0;
        end else if (accept) begin
            req_q <= req_live;
        end
    end

    // Out-of-window flag for the access in flight; forces zero load data until the next access.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            err_q <= 1'b0;
        end else if (access) begin
            err_q <= !acc_in_win;
        end
    end

endmodule

// File: tb/tb_rv32i_dmem_responder.sv
// Bench for rv32i_dmem_responder: three instances with 0, 2 and 3 wait states.
// Latency: checks ack timing cycle-exactly against the issue cycle.
// Backpressure: checks stall pattern during wait states and its absence at full rate.
module tb_rv32i_dmem_responder;

    localparam int          DEPTH = 64;
    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam logic [31:0] TOP   = BASE + 32'(4 * DEPTH);

    logic i_clk   = 1'b0;
    logic i_rst_n = 1'b0;
    always #5 i_clk = ~i_clk;

    rv32i_dmem_responder_if b0 ();
    rv32i_dmem_responder_if b2 ();
    rv32i_dmem_responder_if b3 ();

    rv32i_dmem_responder #(.MEM_DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_STATES(0), .MEM_INIT_FILE(""))
        dut0 (.i_clk(i_clk), .i_rst_n(i_rst_n), .bus(b0));
    rv32i_dmem_responder #(.MEM_DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_STATES(2), .MEM_INIT_FILE(""))
        dut2 (.i_clk(i_clk), .i_rst_n(i_rst_n), .bus(b2));
    rv32i_dmem_responder #(.MEM_DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_STATES(3), .MEM_INIT_FILE(""))
        dut3 (.i_clk(i_clk), .i_rst_n(i_rst_n), .bus(b3));

    typedef struct {
        logic [31:0] data;
        bit          known;
        bit          err;
        int          cyc;
    } exp_t;

    int          tests_run    = 0;
    int          tests_failed = 0;
    int          cyc          = 0;
    exp_t        sbq [$];
    logic [31:0] model  [DEPTH];
    bit          mvalid [DEPTH];

    always @(posedge i_clk) cyc <= cyc + 1;

    // Scoreboard for the zero-wait instance: every ack pops one expectation.
    exp_t me;
    always @(negedge i_clk) begin
        if (i_rst_n) begin
            if (b0.ack) begin
                if (sbq.size() == 0) begin
                    tests_run++;
                    tests_failed++;
                    $display("FAIL d0_unexpected_ack: got ack data=%h, required no ack", b0.data_load);
                end else begin
                    me = sbq.pop_front();
                    tests_run++;
                    if ((me.known && (b0.data_load !== me.data)) || (b0.err !== me.err) || (cyc != me.cyc + 1)) begin
                        tests_failed++;
                        $display("FAIL d0_resp: got data=%h err=%b cycle=%0d, required data=%h(known=%0d) err=%b cycle=%0d",
                                 b0.data_load, b0.err, cyc, me.data, me.known, me.err, me.cyc + 1);
                    end
                end
            end else if (b0.err !== 1'b0) begin
                tests_run++;
                tests_failed++;
                $display("FAIL d0_err_without_ack: got err=%b, required 0", b0.err);
            end
        end
    end

    // Issue one request on the zero-wait instance (called just after a rising edge).
    task automatic d0_req(input logic [31:0] addr, input bit we, input logic [3:0] mask,
                          input logic [31:0] dat, input bit chk_stall);
        exp_t e;
        int   idx;
        b0.stb        = 1'b1;
        b0.addr       = addr;
        b0.wr_en      = we;
        b0.wr_mask    = mask;
        b0.data_store = dat;
        e.cyc = cyc;
        if ((addr < BASE) || (addr >= TOP)) begin
            e.data  = 32'h0;
            e.known = 1'b1;
            e.err   = 1'b1;
        end else begin
            idx     = int'((addr - BASE) >> 2);
            e.data  = model[idx];
            e.known = mvalid[idx];
            e.err   = 1'b0;
            if (we) begin
                for (int b = 0; b < 4; b++) begin
                    if (mask[b]) model[idx][8*b +: 8] = dat[8*b +: 8];
                end
                if (mask == 4'hF) mvalid[idx] = 1'b1;
            end
        end
        sbq.push_back(e);
        if (chk_stall) begin
            @(negedge i_clk);
            tests_run++;
            if (b0.stall !== 1'b0) begin
                tests_failed++;
                $display("FAIL d0_stall: got %b, required 0", b0.stall);
            end
        end
        @(posedge i_clk);
        #1;
    endtask

    task automatic d0_idle();
        b0.stb     = 1'b0;
        b0.wr_en   = 1'b0;
        b0.wr_mask = 4'h0;
        @(posedge i_clk);
        #1;
    endtask

    task automatic d0_drain(input string name);
        for (int i = 0; i < 10 && sbq.size() != 0; i++) @(posedge i_clk);
        #1;
        tests_run++;
        if (sbq.size() != 0) begin
            tests_failed++;
            $display("FAIL %s_drain: got %0d responses outstanding, required 0", name, sbq.size());
            sbq.delete();
        end
    endtask

    task automatic test_reset();
        b0.stb = 0; b0.addr = 0; b0.wr_en = 0; b0.wr_mask = 0; b0.data_store = 0;
        b2.stb = 0; b2.addr = 0; b2.wr_en = 0; b2.wr_mask = 0; b2.data_store = 0;
        b3.stb = 0; b3.addr = 0; b3.wr_en = 0; b3.wr_mask = 0; b3.data_store = 0;
        for (int i = 0; i < DEPTH; i++) begin
            model[i]  = 32'h0;
            mvalid[i] = 1'b0;
        end
        i_rst_n = 1'b0;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        tests_run++;
        if ({b0.ack, b0.stall, b0.err, b0.data_load} !== 35'h0) begin
            tests_failed++;
            $display("FAIL reset_d0: got ack=%b stall=%b err=%b data=%h, required all 0", b0.ack, b0.stall, b0.err, b0.data_load);
        end
        tests_run++;
        if ({b2.ack, b2.stall, b2.err, b2.data_load} !== 35'h0) begin
            tests_failed++;
            $display("FAIL reset_d2: got ack=%b stall=%b err=%b data=%h, required all 0", b2.ack, b2.stall, b2.err, b2.data_load);
        end
        tests_run++;
        if ({b3.ack, b3.stall, b3.err, b3.data_load} !== 35'h0) begin
            tests_failed++;
            $display("FAIL reset_d3: got ack=%b stall=%b err=%b data=%h, required all 0", b3.ack, b3.stall, b3.err, b3.data_load);
        end
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_reset_in_flight();
        bit got;
        // Preload a known word on the three-wait instance.
        b3.stb = 1; b3.addr = 32'h1010; b3.wr_en = 1; b3.wr_mask = 4'hF; b3.data_store = 32'h1234_5678;
        @(posedge i_clk); #1;
        b3.stb = 0;
        got = 0;
        for (int i = 0; i < 12 && !got; i++) begin
            @(negedge i_clk);
            if (b3.ack === 1'b1) got = 1;
        end
        tests_run++;
        if (!got) begin
            tests_failed++;
            $display("FAIL rif_preload_ack: got no ack in 12 cycles, required ack");
        end
        // Store that is reset away while still waiting.
        @(posedge i_clk); #1;
        b3.stb = 1; b3.data_store = 32'hFFFF_FFFF;
        @(posedge i_clk); #1;
        b3.stb = 0;
        @(posedge i_clk); #1;
        i_rst_n = 1'b0;
        @(negedge i_clk);
        tests_run++;
        if ({b3.ack, b3.stall, b3.data_load} !== 34'h0) begin
            tests_failed++;
            $display("FAIL rif_in_reset: got ack=%b stall=%b data=%h, required all 0", b3.ack, b3.stall, b3.data_load);
        end
        repeat (3) @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        @(negedge i_clk);
        tests_run++;
        if ({b3.ack, b3.stall, b3.data_load} !== 34'h0) begin
            tests_failed++;
            $display("FAIL rif_after_reset: got ack=%b stall=%b data=%h, required all 0", b3.ack, b3.stall, b3.data_load);
        end
        // The dropped store must not have reached the RAM.
        @(posedge i_clk); #1;
        b3.stb = 1; b3.wr_en = 0; b3.wr_mask = 0; b3.addr = 32'h1010;
        @(posedge i_clk); #1;
        b3.stb = 0;
        got = 0;
        for (int i = 0; i < 12 && !got; i++) begin
            @(negedge i_clk);
            if (b3.ack === 1'b1) got = 1;
        end
        tests_run++;
        if (!got || (b3.data_load !== 32'h1234_5678) || (b3.err !== 1'b0)) begin
            tests_failed++;
            $display("FAIL rif_readback: got ack=%0d data=%h err=%b, required ack data=12345678 err=0", got, b3.data_load, b3.err);
        end
        @(posedge i_clk); #1;
    endtask

    task automatic test_store_load();
        d0_req(32'h1000, 1, 4'hF, 32'h0BAD_F00D, 0);
        d0_idle();
        d0_req(32'h1000, 1, 4'hF, 32'hDEAD_BEEF, 0);
        d0_req(32'h1000, 0, 4'h0, 32'h0, 0);
        d0_idle();
        d0_drain("store_load");
    endtask

    task automatic test_byte_mask();
        d0_req(32'h1004, 1, 4'hF,    32'h1122_3344, 0);
        d0_req(32'h1004, 1, 4'b0100, 32'h00AB_0000, 0);
        d0_req(32'h1004, 1, 4'b0000, 32'hFFFF_FFFF, 0);
        d0_req(32'h1004, 0, 4'h0,    32'h0, 0);
        d0_idle();
        d0_drain("byte_mask");
        tests_run++;
        if (model[1] !== 32'h11AB_3344) begin
            tests_failed++;
            $display("FAIL byte_mask_model: got %h, required 11ab3344", model[1]);
        end
    endtask

    task automatic test_wait_states();
        bit got;
        b2.stb = 1; b2.addr = 32'h1008; b2.wr_en = 1; b2.wr_mask = 4'hF; b2.data_store = 32'hCAFE_F00D;
        @(posedge i_clk); #1;
        b2.stb = 0;
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge i_clk);
            if (b2.ack === 1'b1) got = 1;
        end
        tests_run++;
        if (!got) begin
            tests_failed++;
            $display("FAIL ws_preload_ack: got no ack in 10 cycles, required ack");
        end
        // Cycle 0: load presented and held through the wait cycles.
        @(posedge i_clk); #1;
        b2.stb = 1; b2.wr_en = 0; b2.wr_mask = 0; b2.addr = 32'h1008;
        for (int c = 1; c <= 5; c++) begin
            @(posedge i_clk); #1;
            if (c == 3) b2.stb = 0;
            @(negedge i_clk);
            tests_run++;
            if ((b2.stall !== ((c == 1) || (c == 2))) || (b2.ack !== (c == 3))) begin
                tests_failed++;
                $display("FAIL ws_timing_c%0d: got stall=%b ack=%b, required stall=%b ack=%b",
                         c, b2.stall, b2.ack, (c == 1) || (c == 2), c == 3);
            end
            if ((c == 3) || (c == 5)) begin
                tests_run++;
                if (b2.data_load !== 32'hCAFE_F00D) begin
                    tests_failed++;
                    $display("FAIL ws_data_c%0d: got %h, required cafef00d", c, b2.data_load);
                end
            end
        end
        @(posedge i_clk); #1;
    endtask

    task automatic test_window();
        d0_req(32'h0000_0FFC, 0, 4'h0, 32'h0, 0);
        d0_req(TOP,           0, 4'h0, 32'h0, 0);
        d0_req(32'hFFFF_FFFC, 0, 4'h0, 32'h0, 0);
        d0_req(TOP,           1, 4'hF, 32'h7777_7777, 0);
        d0_req(TOP - 32'd4,   1, 4'hF, 32'hA5A5_5A5A, 0);
        d0_req(TOP - 32'd4,   0, 4'h0, 32'h0, 0);
        d0_req(32'h1000,      0, 4'h0, 32'h0, 0);
        d0_idle();
        d0_drain("window");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++)
            d0_req(32'h1020 + 32'(4 * i), 1, 4'hF, 32'h5A00_0000 ^ (32'h0101_0101 * 32'(i + 1)), 0);
        for (int i = 0; i < 8; i++)
            d0_req(32'h1020 + 32'(4 * i), 0, 4'h0, 32'h0, 1);
        d0_idle();
        d0_drain("back_to_back");
    endtask

    initial begin
        test_reset();
        test_reset_in_flight();
        test_store_load();
        test_byte_mask();
        test_wait_states();
        test_window();
        test_back_to_back();
        repeat (2) @(posedge i_clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by 200000 time units, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
